// File: rtl/game_pkg.sv
// Shared game types and screen constants for the sprite pipeline.
package game_pkg;

    typedef enum logic [1:0] {
        MARCH,
        DROP,
        LANDED
    } motion_state_t;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int SPRITE_SCALE = 2;
    localparam int SPRITE_PX    = 8 * SPRITE_SCALE;
    localparam int COORD_W      = 10;

endpackage

// File: rtl/frame_step_div.sv
// Frame-tick divider: counts qualified ticks and fires step once per period.
module frame_step_div #(
    parameter int PER_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             run,
    input  logic [PER_W-1:0] period,
    output logic             step
);

    logic [PER_W-1:0] count;
    logic             wrap;

    assign wrap = (count == period - PER_W'(1));
    assign step = tick & run & wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick && run) begin
            count <= wrap ? '0 : count + PER_W'(1);
        end
    end

endmodule

// File: rtl/enemy_motion_ctrl.sv
// Space-Invaders style enemy marcher feeding the sprite renderer position.
// Optional ENEMY_SPEEDUP_EN: step period shrinks by one frame per row drop.
module enemy_motion_ctrl
    import game_pkg::*;
#(
    parameter int X_START         = 16,
    parameter int Y_START         = 32,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 624,
    parameter int STEP_X          = 2,
    parameter int STEP_Y          = 16,
    parameter int FRAMES_PER_STEP = 4,
    parameter int Y_LIMIT         = 448
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               enable,
    input  logic               hit,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               alive,
    output logic               landed,
    output logic               dir_right,
    output logic               anim_frame
);

    localparam int PER_W = $clog2(FRAMES_PER_STEP + 1);

    localparam logic [COORD_W:0]   X_MAX_W      = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0]   LEFT_LIMIT_W = (COORD_W+1)'(X_MIN + STEP_X);
    localparam logic [COORD_W:0]   STEP_X_W     = (COORD_W+1)'(STEP_X);
    localparam logic [COORD_W:0]   STEP_Y_W     = (COORD_W+1)'(STEP_Y);
    localparam logic [COORD_W:0]   Y_LIMIT_W    = (COORD_W+1)'(Y_LIMIT);
    localparam logic [COORD_W-1:0] X_MAX_C      = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] X_MIN_C      = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] STEP_X_C     = COORD_W'(STEP_X);

    motion_state_t      state, state_nxt;
    logic [COORD_W-1:0] x_nxt, y_nxt;
    logic               alive_nxt, landed_nxt, dir_nxt, anim_nxt;
    logic [COORD_W:0]   sum_x, sum_y;
    logic [PER_W-1:0]   period;
    logic               run, hit_now, step;

    assign run     = enable & alive & (state != LANDED);
    assign hit_now = hit & alive & (state != LANDED);
    assign sum_x   = {1'b0, pos_x} + STEP_X_W;
    assign sum_y   = {1'b0, pos_y} + STEP_Y_W;

    frame_step_div #(
        .PER_W (PER_W)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .tick   (frame_tick),
        .run    (run),
        .period (period),
        .step   (step)
    );

`ifdef ENEMY_SPEEDUP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period <= PER_W'(FRAMES_PER_STEP);
        end else if (step && !hit_now && state == DROP && period > PER_W'(1)) begin
            period <= period - PER_W'(1);
        end
    end
`else
    assign period = PER_W'(FRAMES_PER_STEP);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= MARCH;
            pos_x      <= COORD_W'(X_START);
            pos_y      <= COORD_W'(Y_START);
            alive      <= 1'b1;
            landed     <= 1'b0;
            dir_right  <= 1'b1;
            anim_frame <= 1'b0;
        end else begin
            state      <= state_nxt;
            pos_x      <= x_nxt;
            pos_y      <= y_nxt;
            alive      <= alive_nxt;
            landed     <= landed_nxt;
            dir_right  <= dir_nxt;
            anim_frame <= anim_nxt;
        end
    end

    // A hit in the same cycle as a step takes priority and suppresses motion.
    always_comb begin
        state_nxt  = state;
        x_nxt      = pos_x;
        y_nxt      = pos_y;
        alive_nxt  = alive;
        landed_nxt = landed;
        dir_nxt    = dir_right;
        anim_nxt   = anim_frame;
        if (hit_now) begin
            alive_nxt = 1'b0;
        end else if (step) begin
            case (state)
                MARCH: begin
                    anim_nxt = ~anim_frame;
                    if (dir_right) begin
                        if (sum_x >= X_MAX_W) begin
                            x_nxt     = X_MAX_C;
                            state_nxt = DROP;
                        end else begin
                            x_nxt = sum_x[COORD_W-1:0];
                        end
                    end else if ({1'b0, pos_x} <= LEFT_LIMIT_W) begin
                        x_nxt     = X_MIN_C;
                        state_nxt = DROP;
                    end else begin
                        x_nxt = pos_x - STEP_X_C;
                    end
                end
                DROP: begin
                    y_nxt = sum_y[COORD_W-1:0];
                    if (sum_y >= Y_LIMIT_W) begin
                        landed_nxt = 1'b1;
                        state_nxt  = LANDED;
                    end else begin
                        dir_nxt   = ~dir_right;
                        state_nxt = MARCH;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_motion_ctrl.sv
// Bench for enemy_motion_ctrl: four differently parameterised instances share
// stimulus; an abstract marching model is compared against them every cycle.
module tb_enemy_motion_ctrl;

    localparam int N = 4;
    // instance 0: defaults, 1: narrow right edge, 2: left clamp, 3: landing
    localparam int XS  [N] = '{16, 16, 3, 16};
    localparam int YS  [N] = '{32, 32, 32, 432};
    localparam int XMX [N] = '{624, 20, 5, 20};
    localparam int FPS [N] = '{4, 1, 1, 1};

    logic       clk = 1'b0;
    logic       reset, frame_tick, enable, hit;
    logic [9:0] px [N];
    logic [9:0] py [N];
    logic       al [N];
    logic       ld [N];
    logic       dr [N];
    logic       an [N];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    enemy_motion_ctrl u_def (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable), .hit(hit),
        .pos_x(px[0]), .pos_y(py[0]), .alive(al[0]), .landed(ld[0]),
        .dir_right(dr[0]), .anim_frame(an[0])
    );

    enemy_motion_ctrl #(.X_MAX(20), .FRAMES_PER_STEP(1)) u_edge (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable), .hit(hit),
        .pos_x(px[1]), .pos_y(py[1]), .alive(al[1]), .landed(ld[1]),
        .dir_right(dr[1]), .anim_frame(an[1])
    );

    enemy_motion_ctrl #(.X_START(3), .X_MIN(0), .X_MAX(5), .FRAMES_PER_STEP(1)) u_left (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable), .hit(hit),
        .pos_x(px[2]), .pos_y(py[2]), .alive(al[2]), .landed(ld[2]),
        .dir_right(dr[2]), .anim_frame(an[2])
    );

    enemy_motion_ctrl #(.Y_START(432), .X_MAX(20), .FRAMES_PER_STEP(1), .Y_LIMIT(448)) u_land (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable), .hit(hit),
        .pos_x(px[3]), .pos_y(py[3]), .alive(al[3]), .landed(ld[3]),
        .dir_right(dr[3]), .anim_frame(an[3])
    );

    // Abstract model: integer position, a "drop pending" flag, a tick tally.
    int m_x [N];
    int m_y [N];
    int m_cnt [N];
    int m_per [N];
    bit m_alive [N];
    bit m_landed [N];
    bit m_dir [N];
    bit m_anim [N];
    bit m_drop [N];

    task automatic model_init();
        for (int i = 0; i < N; i++) begin
            m_x[i] = XS[i];  m_y[i] = YS[i];
            m_cnt[i] = 0;    m_per[i] = FPS[i];
            m_alive[i] = 1;  m_landed[i] = 0;
            m_dir[i] = 1;    m_anim[i] = 0;  m_drop[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        if (m_drop[i]) begin
            m_y[i] = m_y[i] + 16;
            m_drop[i] = 0;
            if (m_y[i] >= 448) m_landed[i] = 1;
            else m_dir[i] = !m_dir[i];
`ifdef ENEMY_SPEEDUP_EN
            if (m_per[i] > 1) m_per[i] = m_per[i] - 1;
`endif
        end else begin
            m_anim[i] = !m_anim[i];
            if (m_dir[i]) begin
                if (m_x[i] + 2 >= XMX[i]) begin m_x[i] = XMX[i]; m_drop[i] = 1; end
                else m_x[i] = m_x[i] + 2;
            end else begin
                if (m_x[i] - 2 <= 0) begin m_x[i] = 0; m_drop[i] = 1; end
                else m_x[i] = m_x[i] - 2;
            end
        end
    endtask

    initial begin
        model_init();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_init();
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (m_alive[i] && !m_landed[i]) begin
                        if (hit) begin
                            m_alive[i] = 0;
                        end else if (frame_tick && enable) begin
                            m_cnt[i] = m_cnt[i] + 1;
                            if (m_cnt[i] >= m_per[i]) begin
                                m_cnt[i] = 0;
                                model_step(i);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [23:0] got, exp;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                got = {px[i], py[i], al[i], ld[i], dr[i], an[i]};
                exp = {m_x[i][9:0], m_y[i][9:0], m_alive[i], m_landed[i], m_dir[i], m_anim[i]};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL model inst%0d @%0t: got x=%0d y=%0d alv=%b lnd=%b dir=%b anm=%b expected x=%0d y=%0d alv=%b lnd=%b dir=%b anm=%b",
                             i, $time, px[i], py[i], al[i], ld[i], dr[i], an[i],
                             m_x[i], m_y[i], m_alive[i], m_landed[i], m_dir[i], m_anim[i]);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); frame_tick = 1'b1;
            @(negedge clk); frame_tick = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; enable = 1'b1; hit = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_x", px[0], 16);       chk("rst_y", py[0], 32);
        chk("rst_alive", al[0], 1);    chk("rst_landed", ld[0], 0);
        chk("rst_dir", dr[0], 1);      chk("rst_anim", an[0], 0);

        ticks(2);
        chk("edge_clamp_x", px[1], 20);
        ticks(1);
        chk("edge_drop_y", py[1], 48); chk("edge_dir", dr[1], 0);
        chk("land_y", py[3], 448);     chk("land_flag", ld[3], 1);
        ticks(1);
        chk("def_x4", px[0], 18);      chk("def_anim4", an[0], 1);
        chk("edge_back_x", px[1], 18); chk("left_x1", px[2], 1);
        ticks(1);
        chk("left_clamp_x", px[2], 0);
        ticks(1);
        chk("left_drop_y", py[2], 64);
        ticks(2);
        chk("def_x8", px[0], 20);      chk("def_anim8", an[0], 0);

        ticks(2);
        enable = 1'b0;
        ticks(10);
        chk("en_off_x", px[0], 20);
        enable = 1'b1;
        ticks(1);
        chk("cnt_hold_x", px[0], 20);
        ticks(1);
        chk("cnt_resume_x", px[0], 22);

        ticks(3);
        @(negedge clk); frame_tick = 1'b1; hit = 1'b1;
        @(negedge clk); frame_tick = 1'b0; hit = 1'b0;
        @(negedge clk);
        chk("hit_alive", al[0], 0);    chk("hit_x", px[0], 22);
        chk("land_hit_ignored", al[3], 1);
        ticks(20);
        chk("dead_x", px[0], 22);      chk("dead_y", py[0], 32);
        chk("land_hold_x", px[3], 20); chk("land_hold_y", py[3], 448);

        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        ticks(2);
        chk("pre_rst_x", px[1], 20);
        @(negedge clk); #3 reset = 1'b1;
        #1;
        chk("async_rst_x", px[1], 16); chk("async_rst_y", py[1], 32);
        chk("async_rst_dir", dr[1], 1);
        @(negedge clk); reset = 1'b0;
        chk("rst2_alive", al[0], 1);
        @(negedge clk); frame_tick = 1'b1;
        repeat (3) @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        chk("held_tick_x", px[1], 20); chk("held_tick_y", py[1], 48);
        chk("held_tick_dir", dr[1], 0); chk("held_def_x", px[0], 16);

        ticks(1300);
`ifdef ENEMY_SPEEDUP_EN
        chk("long_x", px[0], 570);
        chk("long_anim", an[0], 1);
`else
        chk("long_x", px[0], 584);
        chk("long_anim", an[0], 0);
`endif
        chk("long_y", py[0], 48);      chk("long_dir", dr[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
